// File: rtl/mul_shift_add_32.sv
// Multi-cycle unsigned shift-add multiplier: one ripple-carry add per clock,
// start/busy/done handshake, 2*WIDTH-bit product held until the next start.
module mul_shift_add_32 #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] w_y;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;

   assign w_y    = r_lo[0] ? r_mcand : '0;
   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   // Adder: bit-level ripple-carry at 32 bits, behavioural add otherwise; cin is tied low.
   generate
      if (WIDTH == 32) begin : g_rca
         always_comb begin : p_rca
            logic v_c;
            v_c   = 1'b0;
            w_sum = '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
               w_sum[i] = r_hi[i] ^ w_y[i] ^ v_c;
               v_c      = (r_hi[i] & w_y[i]) | (v_c & (r_hi[i] ^ w_y[i]));
            end
            w_cout = v_c;
         end
      end else begin : g_beh
         assign {w_cout, w_sum} = (WIDTH+1)'(r_hi) + (WIDTH+1)'(w_y);
      end
   endgenerate

   // Next-state logic; start is only honoured in IDLE or DONE.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_accept    = 1'b1;
            end
         end
         S_RUN: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_accept    = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         busy    <= (w_state_nxt == S_RUN);
         done    <= (w_state_nxt == S_DONE);
      end
   end

   // Datapath: {hi,lo} shifts right by one each iteration, carry-out entering at the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_cnt   <= '0;
         product <= '0;
      end else if (w_accept) begin
         r_mcand <= a;
         r_hi    <= '0;
         r_lo    <= b;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_hi  <= {w_cout, w_sum[WIDTH-1:1]};
         r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_last) product <= {w_cout, w_sum, r_lo[WIDTH-1:1]};
      end
   end

endmodule

// File: tb/tb_mul_shift_add_32.sv
// Scoreboard bench for mul_shift_add_32: expected products and done cycles are
// queued at issue time and checked by an independent monitor on each done pulse.
module tb_mul_shift_add_32;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [63:0] product;

   typedef struct {
      logic [63:0] prod;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   mul_shift_add_32 #(.WIDTH(32), .CNT_W(6)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done with empty scoreboard, product %h (cycle %0d)",
                     product, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("product", product, e.prod);
            check("latency", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Issue one request at the current negedge and follow it to its done pulse.
   // mode 0: quiet inputs; 1: random start/a/b during RUN; 2: start held high, random a/b.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input int mode);
      exp_t e;
      int   nbusy;
      bit   got;
      nbusy  = 0;
      got    = 1'b0;
      start  = 1'b1;
      a      = ta;
      b      = tb_;
      e.prod = 64'(ta) * 64'(tb_);
      e.cyc  = cyc + 33;
      q.push_back(e);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
         if (busy) nbusy++;
         case (mode)
            0: start = 1'b0;
            1: begin
               start = 1'($urandom_range(0, 1));
               a     = $urandom;
               b     = $urandom;
            end
            default: begin
               start = 1'b1;
               a     = $urandom;
               b     = $urandom;
            end
         endcase
      end
      check("done_seen", 64'(got), 64'd1);
      check("busy_cycles", 64'(nbusy), 64'd32);
      check("busy_at_done", 64'(busy), 64'd0);
   endtask

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #3 rst_n = 1'b0;
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_product", product, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(32'd3, 32'd5, 0);
      start = 1'b0;
      @(negedge clk);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      start = 1'b0;
      @(negedge clk);
      run_op(32'h8000_0000, 32'd2, 0);
      start = 1'b0;
      @(negedge clk);
      run_op(32'd0, 32'hDEAD_BEEF, 0);
      start = 1'b0;
      @(negedge clk);

      // Start held through RUN, then a fresh request during DONE.
      run_op(32'd7, 32'd9, 2);
      run_op(32'd10, 32'd10, 0);
      start = 1'b0;
      @(negedge clk);

      // Abort mid-multiply with an asynchronous reset.
      start = 1'b1;
      a     = 32'd1234;
      b     = 32'd5678;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      q.delete();
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_product", product, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(32'd2, 32'd3, 0);
      start = 1'b0;
      @(negedge clk);

      // Random requests with noisy inputs during RUN and random back-to-back starts.
      for (int n = 0; n < 1000; n++) begin
         run_op($urandom, $urandom, 1);
         if ($urandom_range(0, 1) == 0) begin
            start = 1'b0;
            @(negedge clk);
         end
      end
      start = 1'b0;
      repeat (40) @(negedge clk);
      check("pending", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
